// File: rtl/pixel_stream_fetcher.sv
// pixel_stream_fetcher
// Walks the frame buffer in raster order, reads grayscale bytes through a
// 1-cycle-latency memory port, buffers them in a small FIFO and presents
// them as {g,g,g} pixels on a valid/ready stream with sop/eop markers.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   enable       level; start/continue fetching frames
//   mem_address  frame-buffer read address (meaningful when mem_rd=1)
//   mem_rd       read issued this cycle
//   mem_data     byte returned the cycle after mem_rd
//   out_data     replicated-gray pixel {g,g,g}
//   out_valid    out_data/out_sop/out_eop valid
//   out_ready    sink accepts this cycle
//   out_sop      pixel at address 0
//   out_eop      pixel at the last frame address
//   frame_done   one-cycle pulse the cycle after the eop pixel transfers
module pixel_stream_fetcher #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [23:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              frame_done
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    FINISHING
  } state_t;

  state_t state, state_next;

  logic             inflight;
  logic             pend_sop;
  logic             pend_eop;
  logic [9:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             has_credit;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [9:0]       head;
  logic             at_first;
  logic             at_last;

  // A read is only allowed when the byte it returns is guaranteed a slot:
  // buffered entries plus the one still on its way must leave room.
  assign has_credit = (count + CNT_W'(inflight)) < DEPTH_C;
  assign fifo_wr    = inflight;
  assign fifo_rd    = out_valid && out_ready;
  assign head       = fifo_mem[rd_ptr];
  assign at_first   = (mem_address == '0);
  assign at_last    = (mem_address == LAST_ADDR);

  // Outputs are forced to zero while empty so reset clears them without
  // needing to reset the storage array.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? {head[7:0], head[7:0], head[7:0]} : 24'h0;
  assign out_sop   = out_valid && head[9];
  assign out_eop   = out_valid && head[8];

  // Next-state and read-issue logic. Dropping enable at address 0 means the
  // frame boundary has been reached, so no further read is issued; dropping
  // it anywhere else lets the current frame finish being fetched.
  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    case (state)
      STOPPED: begin
        if (enable) state_next = RUNNING;
      end
      RUNNING: begin
        if (enable || !at_first) mem_rd = has_credit;
        if (!enable) begin
          if (at_first)                 state_next = STOPPED;
          else if (mem_rd && at_last)   state_next = STOPPED;
          else                          state_next = FINISHING;
        end
      end
      FINISHING: begin
        mem_rd = has_credit;
        if (enable)                     state_next = RUNNING;
        else if (mem_rd && at_last)     state_next = STOPPED;
      end
      default: state_next = STOPPED;
    endcase
  end

  // State register and raster address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= STOPPED;
      mem_address <= '0;
    end else begin
      state <= state_next;
      if (mem_rd) mem_address <= at_last ? '0 : mem_address + ADDR_W'(1);
    end
  end

  // The sideband flags travel one cycle behind the read so they line up with
  // the returning byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= 1'b0;
      pend_sop <= 1'b0;
      pend_eop <= 1'b0;
    end else begin
      inflight <= mem_rd;
      pend_sop <= at_first;
      pend_eop <= at_last;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {pend_sop, pend_eop, mem_data};
  end

  // FIFO pointers and occupancy. Simultaneous write and read leave the
  // occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame completion pulse follows the eop transfer by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= fifo_rd && head[8];
  end

endmodule
